// File: rtl/lamp_fpu_sqrt_ctrl_pkg.sv
// Shared types, constants and operand classification for the lampFPU sqrt front-end.
package lamp_fpu_sqrt_ctrl_pkg;

    localparam int unsigned LAMP_FLOAT_DW   = 16;
    localparam int unsigned LAMP_FLOAT_E_DW = 8;
    localparam int unsigned LAMP_FLOAT_F_DW = 7;
    localparam int unsigned LAMP_FLOAT_BIAS = 127;

    localparam logic [LAMP_FLOAT_DW-1:0] QNAN = 16'h7FC0;
    localparam logic [LAMP_FLOAT_DW-1:0] PINF = 16'h7F80;
    localparam logic [LAMP_FLOAT_DW-1:0] NINF = 16'hFF80;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StPack,
        StDone
    } sqrt_state_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_neg;
    } float_class_t;

    // Denormals (e == 0, m != 0) are treated as zero.
    function automatic float_class_t classify(input logic [LAMP_FLOAT_DW-1:0] op);
        float_class_t c;
        c.is_zero = (op[14:7] == 8'h00);
        c.is_inf  = (op[14:7] == 8'hFF) && (op[6:0] == 7'h00);
        c.is_nan  = (op[14:7] == 8'hFF) && (op[6:0] != 7'h00);
        c.is_neg  = op[15];
        return c;
    endfunction

endpackage

// File: rtl/lamp_fpu_sqrt_ctrl_if.sv
// Request / result / core-side signal bundle of the sqrt front-end.
interface lamp_fpu_sqrt_ctrl_if;
    logic        doSqrt_i;
    logic        doInvSqrt_i;
    logic [15:0] op_i;
    logic        busy_o;
    logic [15:0] result_o;
    logic        valid_o;
    logic        err_o;
    logic        core_doSqrt_o;
    logic        core_doInvSqrt_o;
    logic [8:0]  core_f_o;
    logic [15:0] core_result_i;
    logic        core_valid_i;

    // Environment side: requester plus the iterative core.
    modport master (
        output doSqrt_i, doInvSqrt_i, op_i, core_result_i, core_valid_i,
        input  busy_o, result_o, valid_o, err_o, core_doSqrt_o, core_doInvSqrt_o, core_f_o
    );

    // Controller side.
    modport slave (
        input  doSqrt_i, doInvSqrt_i, op_i, core_result_i, core_valid_i,
        output busy_o, result_o, valid_o, err_o, core_doSqrt_o, core_doInvSqrt_o, core_f_o
    );
endinterface

// File: rtl/lamp_fpu_sqrt_round.sv
// Normalise a Q1.15 core result, round to nearest even and pack a positive float.
module lamp_fpu_sqrt_round
    import lamp_fpu_sqrt_ctrl_pkg::*;
(
    input  logic [15:0] r,
    input  logic [7:0]  eb,
    output logic [15:0] res
);

    logic [15:0] rn;
    logic [7:0]  en;
    logic [6:0]  mant;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic [7:0]  mant_sum;
    logic [7:0]  e_out;

    // One-bit normalisation, then RNE with mantissa carry into the exponent.
    always_comb begin
        rn       = r[15] ? r : {r[14:0], 1'b0};
        en       = r[15] ? eb : eb - 8'd1;
        mant     = rn[14:8];
        guard    = rn[7];
        sticky   = |rn[6:0];
        inc      = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + {7'd0, inc};
        e_out    = en + {7'd0, mant_sum[7]};
        res      = {1'b0, e_out, mant_sum[6:0]};
    end

endmodule

// File: rtl/lamp_fpu_sqrt_ctrl.sv
// Sqrt / invsqrt front-end: special-value handling, core issue, timeout and result packing.
module lamp_fpu_sqrt_ctrl
    import lamp_fpu_sqrt_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input logic                 clk,
    input logic                 rst,
    lamp_fpu_sqrt_ctrl_if.slave bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic signed [9:0] BiasS = 10'(LAMP_FLOAT_BIAS);

    sqrt_state_t   state_q, state_d;
    logic          inv_q, inv_d;
    logic [8:0]    f_q, f_d;
    logic [7:0]    eb_q, eb_d;
    logic [15:0]   r_q, r_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [15:0]   result_q, result_d;
    logic          valid_q, valid_d;
    logic          err_out_q, err_out_d;
    logic          do_sqrt, do_inv;

    float_class_t      cls;
    logic              is_special;
    logic              start_inv;
    logic [15:0]       spec_res;
    logic signed [9:0] exp_unb;
    logic signed [9:0] half;
    logic signed [9:0] eb_full;
    logic [8:0]        f_new;
    logic [15:0]       packed_res;

    // Operand decode for the request currently presented in IDLE; sqrt wins a tie.
    always_comb begin
        cls        = classify(bus.op_i);
        is_special = cls.is_zero | cls.is_inf | cls.is_nan | cls.is_neg;
        start_inv  = ~bus.doSqrt_i;
        exp_unb    = $signed({2'b00, bus.op_i[14:7]}) - BiasS;
        // floor((E+1)/2) equals E/2 for even E and (E+1)/2 for odd E.
        half       = (exp_unb + 10'sd1) >>> 1;
        eb_full    = start_inv ? (BiasS - half) : (BiasS + half);
        f_new      = exp_unb[0] ? {2'b01, bus.op_i[6:0]} : {1'b1, bus.op_i[6:0], 1'b0};
        spec_res   = QNAN;
        if (cls.is_nan || (cls.is_neg && !cls.is_zero)) begin
            spec_res = QNAN;
        end else if (start_inv) begin
            spec_res = cls.is_zero ? (cls.is_neg ? NINF : PINF) : 16'h0000;
        end else begin
            spec_res = cls.is_zero ? {bus.op_i[15], 15'd0} : PINF;
        end
    end

    lamp_fpu_sqrt_round u_round (
        .r   (r_q),
        .eb  (eb_q),
        .res (packed_res)
    );

    // Next-state and Moore core-start outputs.
    always_comb begin
        state_d   = state_q;
        inv_d     = inv_q;
        f_d       = f_q;
        eb_d      = eb_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        err_out_d = 1'b0;
        do_sqrt   = 1'b0;
        do_inv    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.doSqrt_i || bus.doInvSqrt_i) begin
                    inv_d = start_inv;
                    err_d = 1'b0;
                    if (is_special) begin
                        result_d = spec_res;
                        state_d  = StDone;
                    end else begin
                        f_d     = f_new;
                        eb_d    = eb_full[7:0];
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                do_sqrt = ~inv_q;
                do_inv  = inv_q;
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (bus.core_valid_i) begin
                    r_d     = bus.core_result_i;
                    state_d = StPack;
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    result_d = QNAN;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPack: begin
                result_d = packed_res;
                state_d  = StDone;
            end
            StDone: begin
                valid_d   = 1'b1;
                err_out_d = err_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            inv_q     <= 1'b0;
            f_q       <= '0;
            eb_q      <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inv_q     <= inv_d;
            f_q       <= f_d;
            eb_q      <= eb_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            err_out_q <= err_out_d;
        end
    end

    assign bus.busy_o           = (state_q != StIdle);
    assign bus.result_o         = result_q;
    assign bus.valid_o          = valid_q;
    assign bus.err_o            = err_out_q;
    assign bus.core_doSqrt_o    = do_sqrt;
    assign bus.core_doInvSqrt_o = do_inv;
    assign bus.core_f_o         = f_q;

endmodule

// File: tb/tb_lamp_fpu_sqrt_ctrl.sv
// Self-checking bench for lamp_fpu_sqrt_ctrl with an arithmetic reference model.
module tb_lamp_fpu_sqrt_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lamp_fpu_sqrt_ctrl_if bus();

    lamp_fpu_sqrt_ctrl #(.TIMEOUT_CYC(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected transaction timeline, filled in by the driver.
    bit          active = 1'b0;
    int          t_start, t_valid;
    bit          t_norm, t_inv, t_err;
    logic [8:0]  t_f;
    logic [15:0] t_res;

    bit          m_spec;
    logic [8:0]  m_f;
    logic [15:0] m_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: result from value arithmetic rather than bit fields.
    function automatic void model(input bit inv, input logic [15:0] op, input logic [15:0] cr,
                                  output bit spec, output logic [8:0] f,
                                  output logic [15:0] res);
        int e, m, ex, half, ev, rv, q, rem;
        bit s, zero, inf, nan;
        e = int'(op[14:7]);
        m = int'(op[6:0]);
        s = op[15];
        if (e == 0) m = 0;
        zero = (e == 0);
        inf  = (e == 255) && (m == 0);
        nan  = (e == 255) && (m != 0);
        spec = zero || inf || nan || s;
        f    = 9'd0;
        res  = 16'h0000;
        if (spec) begin
            if (nan || (s && !zero)) res = 16'h7FC0;
            else if (!inv) res = zero ? {s, 15'd0} : 16'h7F80;
            else if (zero) res = s ? 16'hFF80 : 16'h7F80;
            else res = 16'h0000;
        end else begin
            ev = e - 127;
            if ((ev % 2) == 0) begin
                f    = 9'(256 + 2 * m);
                half = ev / 2;
            end else begin
                f    = 9'(128 + m);
                half = (ev + 1) / 2;
            end
            ex = inv ? 127 - half : 127 + half;
            rv = int'(cr);
            if (rv < 32768) begin
                rv = rv * 2;
                ex = ex - 1;
            end
            q   = rv / 256;
            rem = rv % 256;
            if (rem > 128 || (rem == 128 && (q % 2) == 1)) q = q + 1;
            if (q == 256) begin
                q  = 128;
                ex = ex + 1;
            end
            res = {1'b0, 8'(ex), 7'(q - 128)};
        end
    endfunction

    // Per-cycle comparison of every output against the expected timeline.
    always @(negedge clk) begin
        if (!rst) begin
            if (!active) begin
                chk("idle_valid", 32'(bus.valid_o), 32'd0);
                chk("idle_busy", 32'(bus.busy_o), 32'd0);
                chk("idle_err", 32'(bus.err_o), 32'd0);
                chk("idle_core_do", {30'd0, bus.core_doSqrt_o, bus.core_doInvSqrt_o}, 32'd0);
            end else begin
                chk("valid", 32'(bus.valid_o), 32'(cyc == t_valid));
                chk("err", 32'(bus.err_o), 32'((cyc == t_valid) && t_err));
                if (cyc == t_valid) chk("result", 32'(bus.result_o), 32'(t_res));
                chk("busy", 32'(bus.busy_o), 32'((cyc > t_start) && (cyc < t_valid)));
                chk("core_doSqrt", 32'(bus.core_doSqrt_o),
                    32'(t_norm && !t_inv && (cyc == t_start + 1)));
                chk("core_doInvSqrt", 32'(bus.core_doInvSqrt_o),
                    32'(t_norm && t_inv && (cyc == t_start + 1)));
                if (t_norm && (cyc == t_start + 1)) chk("core_f", 32'(bus.core_f_o), 32'(t_f));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request: lat = cycles from core start pulse to core_valid_i (<0 never answers).
    task automatic run(input bit sq, input bit inv, input logic [15:0] op,
                       input logic [15:0] cr, input int lat, input logic [15:0] lit,
                       input bit ign);
        bit sel_inv;
        int s;
        sel_inv = !sq && inv;
        model(sel_inv, op, cr, m_spec, m_f, m_res);
        if (m_spec || lat >= 0) chk("model_pin", 32'(m_res), 32'(lit));
        s       = cyc;
        t_start = s;
        t_norm  = !m_spec;
        t_inv   = sel_inv;
        t_f     = m_f;
        t_res   = m_res;
        t_err   = 1'b0;
        if (m_spec) begin
            t_valid = s + 2;
        end else if (lat < 0) begin
            t_valid = s + 3 + 15;
            t_res   = 16'h7FC0;
            t_err   = 1'b1;
        end else begin
            t_valid = s + 4 + lat;
        end
        active = 1'b1;
        bus.doSqrt_i    = sq;
        bus.doInvSqrt_i = inv;
        bus.op_i        = op;
        tick();
        bus.doSqrt_i    = 1'b0;
        bus.doInvSqrt_i = 1'b0;
        bus.op_i        = 16'hFFFF;
        while (cyc <= t_valid) begin
            bus.core_valid_i  = !m_spec && (lat >= 0) && (cyc == s + 1 + lat);
            bus.core_result_i = bus.core_valid_i ? cr : 16'hDEAD;
            bus.doSqrt_i      = ign && (cyc == s + 2);
            bus.doInvSqrt_i   = ign && (cyc == s + 2);
            bus.op_i          = (ign && (cyc == s + 2)) ? 16'h3F80 : 16'hFFFF;
            tick();
        end
        bus.core_valid_i = 1'b0;
        bus.doSqrt_i     = 1'b0;
        bus.doInvSqrt_i  = 1'b0;
        active = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_result"}, 32'(bus.result_o), 32'd0);
        chk({tag, "_core_f"}, 32'(bus.core_f_o), 32'd0);
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    endtask

    // Reset while the core is outstanding: no result may ever appear.
    task automatic reset_mid();
        t_start = cyc;
        t_norm  = 1'b1;
        t_inv   = 1'b0;
        t_f     = 9'h100;
        t_res   = 16'h7FC0;
        t_err   = 1'b1;
        t_valid = cyc + 18;
        active  = 1'b1;
        bus.doSqrt_i = 1'b1;
        bus.op_i     = 16'h4080;
        tick();
        bus.doSqrt_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        active = 1'b0;
        reset_check("rst_mid");
        repeat (25) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.doSqrt_i      = 1'b0;
        bus.doInvSqrt_i   = 1'b0;
        bus.op_i          = 16'h0000;
        bus.core_result_i = 16'h0000;
        bus.core_valid_i  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        reset_check("reset");
        tick();

        // Mantissa preparation pins.
        model(1'b0, 16'h4080, 16'h8000, m_spec, m_f, m_res);
        chk("pin_f_4p0", 32'(m_f), 32'h100);
        model(1'b0, 16'h4000, 16'h5A82, m_spec, m_f, m_res);
        chk("pin_f_2p0", 32'(m_f), 32'h080);
        model(1'b0, 16'h3F00, 16'h5A82, m_spec, m_f, m_res);
        chk("pin_f_0p5", 32'(m_f), 32'h080);

        // Normal operands.
        run(1, 0, 16'h4080, 16'h8000, 2, 16'h4000, 0);
        run(1, 0, 16'h4000, 16'h5A82, 3, 16'h3FB5, 0);
        run(0, 1, 16'h4080, 16'h8000, 1, 16'h3F00, 0);
        run(0, 1, 16'h3F80, 16'h8000, 4, 16'h3F80, 0);
        run(1, 0, 16'h3F00, 16'h5A82, 2, 16'h3F35, 0);
        run(0, 1, 16'h3E80, 16'h8000, 1, 16'h4000, 0);

        // Special operands.
        run(1, 0, 16'hBF80, 16'h0000, 0, 16'h7FC0, 0);
        run(0, 1, 16'h0000, 16'h0000, 0, 16'h7F80, 0);
        run(0, 1, 16'h8000, 16'h0000, 0, 16'hFF80, 0);
        run(1, 0, 16'h0001, 16'h0000, 0, 16'h0000, 0);
        run(1, 0, 16'h8000, 16'h0000, 0, 16'h8000, 0);
        run(1, 0, 16'h7F80, 16'h0000, 0, 16'h7F80, 0);
        run(0, 1, 16'h7F80, 16'h0000, 0, 16'h0000, 0);
        run(1, 0, 16'h7FC1, 16'h0000, 0, 16'h7FC0, 0);
        run(0, 1, 16'hFF80, 16'h0000, 0, 16'h7FC0, 0);
        run(0, 1, 16'h8001, 16'h0000, 0, 16'hFF80, 0);

        // Rounding and normalisation on sqrt(1.0), eb = 127.
        run(1, 0, 16'h3F80, 16'h8180, 1, 16'h3F82, 0);
        run(1, 0, 16'h3F80, 16'h8280, 2, 16'h3F82, 0);
        run(1, 0, 16'h3F80, 16'h8080, 1, 16'h3F80, 0);
        run(1, 0, 16'h3F80, 16'hFF80, 3, 16'h4000, 0);
        run(1, 0, 16'h3F80, 16'h81C0, 1, 16'h3F82, 0);
        run(1, 0, 16'h3F80, 16'h4100, 2, 16'h3F02, 0);

        // Control corners.
        run(1, 1, 16'h4080, 16'h8000, 2, 16'h4000, 0);
        run(0, 1, 16'h4080, 16'h8000, 5, 16'h3F00, 1);
        run(1, 0, 16'h4080, 16'h0000, -1, 16'h0000, 0);
        run(0, 1, 16'h3F80, 16'h8000, 1, 16'h3F80, 0);
        reset_mid();
        run(1, 0, 16'h4000, 16'h5A82, 1, 16'h3FB5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
